// File: rtl/pc_fetch_unit_if.sv
// ============================================================================
// pc_fetch_unit_if : fetch-unit control/instruction-memory bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pc_fetch_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [11:0] jump_addr;
    logic [15:0] instruction;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        halted;
    logic [15:0] instr_count;

    modport master (
        input  stall, branch_taken, branch_offset, jump, jump_addr, instruction,
        output pc, pc_plus2, instr_valid, halted, instr_count
    );

    modport slave (
        output stall, branch_taken, branch_offset, jump, jump_addr, instruction,
        input  pc, pc_plus2, instr_valid, halted, instr_count
    );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// pc_fetch_unit : BOOT/RUN/HALT program-counter sequencer with jump/branch.
// Optional instruction counter enabled by macro PC_FETCH_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit (
    input  wire logic       clk,
    input  wire logic       rst_n,
    pc_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_pc;
    logic [15:0] w_pc_next;
    logic [15:0] w_pc_plus2;
    logic [15:0] w_branch_target;
    logic [15:0] w_jump_target;
    logic        w_instr_valid;
    logic        w_halt_word;

    assign w_pc_plus2      = r_pc + 16'd2;
    assign w_halt_word     = (bus.instruction == 16'h0000);
    assign w_branch_target = w_pc_plus2 + (bus.branch_offset << 1);
    assign w_jump_target   = {w_pc_plus2[15:13], bus.jump_addr, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // A halt word wins over any redirect and leaves pc on the halt address.
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_instr_valid = 1'b0;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN: begin
                if (!bus.stall) begin
                    if (w_halt_word) begin
                        w_state_next = ST_HALT;
                    end else begin
                        w_instr_valid = 1'b1;
                        if (bus.jump)
                            w_pc_next = w_jump_target;
                        else if (bus.branch_taken)
                            w_pc_next = w_branch_target;
                        else
                            w_pc_next = w_pc_plus2;
                    end
                end
            end
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_BOOT;
        endcase
    end

    assign bus.pc          = r_pc;
    assign bus.pc_plus2    = w_pc_plus2;
    assign bus.instr_valid = w_instr_valid;
    assign bus.halted      = (r_state == ST_HALT);

`ifdef PC_FETCH_PERF_CNT_EN
    logic [15:0] r_instr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_instr_count <= 16'h0000;
        else if (w_instr_valid && (r_instr_count != 16'hFFFF))
            r_instr_count <= r_instr_count + 16'd1;
    end

    assign bus.instr_count = r_instr_count;
`else
    assign bus.instr_count = 16'h0000;
`endif

endmodule

`default_nettype wire
